// File: rtl/step_unwind_div_if.sv
// Handshake/data bundle for step_unwind_div.
// master: start, abort, k_in out; q, r, k_lat, busy, done in. slave: mirror.
interface step_unwind_div_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] k_in;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] k_lat;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, k_in,
        input  q, r, k_lat, busy, done
    );

    modport slave (
        input  start, abort, k_in,
        output q, r, k_lat, busy, done
    );
endinterface

// File: rtl/step_unwind_div.sv
// Unwinds an accumulated value by repeated subtraction of STEP.
// Ports: clk, rst (sync, active-high), bus (slave): start/abort/k_in in;
// q (quotient), r (remainder), k_lat (latched input), busy, done out.
module step_unwind_div #(
    parameter int WIDTH = 16,
    parameter int STEP  = 50
) (
    input  logic                clk,
    input  logic                rst,
    step_unwind_div_if.slave    bus
);
    if (STEP < 1 || STEP > (2 ** WIDTH) - 1) begin : g_bad_step
        $error("step_unwind_div: STEP out of range 1..2^WIDTH-1");
    end

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] q, q_n;
    logic [WIDTH-1:0] r, r_n;
    logic [WIDTH-1:0] k_lat, k_lat_n;
    logic             busy, busy_n;
    logic             done, done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            r     <= '0;
            k_lat <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            r     <= r_n;
            k_lat <= k_lat_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        r_n     = r;
        k_lat_n = k_lat;
        busy_n  = busy;
        done_n  = done;
        unique case (state)
            IDLE, DONE: begin
                // A start in DONE restarts with no idle cycle in between.
                if (bus.start) begin
                    state_n = RUN;
                    k_lat_n = bus.k_in;
                    r_n     = bus.k_in;
                    q_n     = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    q_n     = '0;
                    r_n     = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b0;
                end else if (r >= STEP_W) begin
                    r_n = r - STEP_W;
                    q_n = q + 1'b1;
                end else begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                q_n     = '0;
                r_n     = '0;
                busy_n  = 1'b0;
                done_n  = 1'b0;
            end
        endcase
    end

    assign bus.q     = q;
    assign bus.r     = r;
    assign bus.k_lat = k_lat;
    assign bus.busy  = busy;
    assign bus.done  = done;

    // Product at double width so the identity cannot alias on overflow.
    logic [2*WIDTH-1:0] recon;
    assign recon = ({{WIDTH{1'b0}}, q} * {{WIDTH{1'b0}}, STEP_W})
                 + {{WIDTH{1'b0}}, r};

    a_identity: assert property (@(posedge clk) disable iff (rst)
        (state != IDLE) |-> (recon == {{WIDTH{1'b0}}, k_lat}));
    a_done_rem: assert property (@(posedge clk) disable iff (rst)
        done |-> (r < STEP_W));
    a_excl: assert property (@(posedge clk) disable iff (rst)
        !(busy && done));
    a_idle_zero: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> (q == '0 && r == '0));
endmodule

// File: tb/tb_step_unwind_div.sv
// Scoreboard bench for step_unwind_div (WIDTH=16, STEP=50).
// Stimulus pushes expected results; a negedge monitor pops on done rising.
module tb_step_unwind_div;
    localparam int W = 16;
    localparam int S = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    step_unwind_div_if #(.WIDTH(W)) bus();

    step_unwind_div #(.WIDTH(W), .STEP(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [W-1:0] k;
        int           edge_n;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on done rising.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.busy || bus.done)
                chk("identity",
                    32'(bus.q) * 32'(S) + 32'(bus.r), 32'(bus.k_lat));
            if (bus.done)
                chk("done_rem_lt_step", 32'(bus.r < W'(S)), 32'd1);
            chk("busy_done_excl", 32'(bus.busy && bus.done), 32'd0);
            if (bus.done && !prev_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("q", 32'(bus.q), 32'(e.q));
                    chk("r", 32'(bus.r), 32'(e.r));
                    chk("k_lat", 32'(bus.k_lat), 32'(e.k));
                    chk("done_edge", 32'(cyc), 32'(e.edge_n));
                end
            end
        end
        prev_done = bus.done;
    end

    // Issue start at a negedge; sampled on the next posedge.
    task automatic issue(input logic [W-1:0] k, input bit expect_done,
                         input logic [W-1:0] eq, input logic [W-1:0] er);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_in  = k;
        if (expect_done) begin
            e.q      = eq;
            e.r      = er;
            e.k      = k;
            e.edge_n = cyc + 1 + int'(eq) + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.k_in  = 16'h1234;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("done_after_start", 32'(bus.done), 32'd0);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.k_in  = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_q", 32'(bus.q), 32'd0);
        chk("rst_r", 32'(bus.r), 32'd0);
        chk("rst_klat", 32'(bus.k_lat), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        issue(16'd2000, 1'b1, 16'd40, 16'd0);
        wait_done();
        issue(16'd49, 1'b1, 16'd0, 16'd49);
        wait_done();
        issue(16'd0, 1'b1, 16'd0, 16'd0);
        wait_done();
        issue(16'hFFFF, 1'b1, 16'd1310, 16'd35);
        wait_done();

        // Abort, with an ignored start mid-run.
        issue(16'd1000, 1'b0, '0, '0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_in  = 16'd7;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign_start_klat", 32'(bus.k_lat), 32'd1000);
        repeat (6) @(negedge clk);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_q", 32'(bus.q), 32'd0);
        chk("abort_r", 32'(bus.r), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_klat", 32'(bus.k_lat), 32'd1000);
        repeat (30) @(negedge clk);
        chk("abort_stays_idle", 32'(bus.busy || bus.done), 32'd0);

        // Reset in the middle of a run.
        issue(16'd500, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_q", 32'(bus.q), 32'd0);
        chk("mid_rst_r", 32'(bus.r), 32'd0);
        chk("mid_rst_klat", 32'(bus.k_lat), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        repeat (20) @(negedge clk);
        chk("mid_rst_no_done", 32'(bus.done), 32'd0);

        // Back-to-back restart from DONE.
        issue(16'd100, 1'b1, 16'd2, 16'd0);
        wait_done();
        issue(16'd275, 1'b1, 16'd5, 16'd25);
        wait_done();

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
